cmac_usplus_0_axis_pkt_mon: RTL
===============================

# cmac_usplus_0_axis_pkt_mon

Receive-side packet monitor for the CMAC 100G example design, the counterpart of the TX packet generator. It sits on the CMAC RX AXI4-Stream output (512-bit, no backpressure) in the `txusrclk2` domain. It checks each received frame for length, payload pattern and FCS status, counts good and bad packets, and raises done/pass indications once `PKT_NUM` packets have arrived.

## Interface
Parameters:
- `PKT_NUM`, 1000: packets expected per run (1–65535).
- `PKT_SIZE`, 522: expected frame length in bytes (64–16000).

Ports:
- `aclk`  in  1  CMAC user clock (`txusrclk2`); the only clock.
- `aresetn`  in  1  Asynchronous, active-low reset.
- `rx_aligned`  in  1  CMAC `stat_rx_aligned`, level.
- `restart`  in  1  Single-cycle pulse that clears counters and re-arms the monitor.
- `rx_axis_tvalid`  in  1  Beat valid. There is no tready; every valid beat must be accepted.
- `rx_axis_tdata`  in  512  Beat data. Lane 0 is `[7:0]` and is the first byte on the wire.
- `rx_axis_tkeep`  in  64  Byte enables.
- `rx_axis_tlast`  in  1  Last beat of the frame.
- `rx_axis_tuser`  in  1  Frame error (bad FCS). Sampled on the tlast beat only.
- `rx_pkt_cnt`  out  16  Frames completed.
- `rx_err_pkt_cnt`  out  16  Frames with one or more errors.
- `rx_len_err_cnt`, `rx_data_err_cnt`, `rx_fcs_err_cnt`  out  16 each  Per-cause error counts.
- `rx_total_bytes`  out  32  Sum of the lengths of completed frames.
- `rx_busy_led`  out  1  High in ARMED or RECV.
- `rx_done_led`  out  1  `PKT_NUM` frames completed.
- `rx_pass`  out  1  Done with zero errored frames.

## Operation
- States and transitions:
  - WAIT_ALIGN → ARMED when `rx_aligned`=1.
  - ARMED → RECV on a valid beat with tlast=0.
  - ARMED → ARMED on a valid beat with tlast=1 (single-beat frame completes immediately).
  - RECV → ARMED on the tlast beat.
  - ARMED/RECV → DONE when the completed-frame count reaches `PKT_NUM`.
  - DONE ignores all beats.
- Lost alignment: `rx_aligned`=0 in ARMED or RECV → WAIT_ALIGN. A partial frame is discarded and not counted. Counters hold their values.
- `restart` (any state): clears all counters and accumulators and goes to WAIT_ALIGN. It has priority over a simultaneous tlast beat, which is dropped.
- Per-frame byte offset k runs from 0. Beat n carries offsets 64n..64n+63.
- Expected payload: byte at offset k equals `k[7:0]`. Only lanes with `tkeep`=1 are compared. Any mismatch sets the frame's data_err flag.
- Length errors (set the frame's len_err flag):
  - A non-tlast beat with `tkeep` ≠ all-ones.
  - A tlast beat with non-contiguous `tkeep`. Only 0…0 followed by 1…1 patterns starting at lane 0 are legal.
  - A tlast beat with `tkeep`=0.
  - Final frame length ≠ `PKT_SIZE`.
- Length accumulation:
  - Each beat adds the popcount of its `tkeep` to a 14-bit length accumulator.
  - The accumulator saturates at 16383. Any saturated value is a length error.
  - The byte offset counter saturates as well; offsets wrap modulo 256 for the pattern compare.
- `tuser`=1 on the tlast beat sets the frame's fcs_err flag.
- Frame completion:
  - `rx_pkt_cnt` increments by 1.
  - `rx_total_bytes` adds the frame length.
  - Each per-cause counter increments by 1 if its flag is set.
  - `rx_err_pkt_cnt` increments by 1 if any flag is set.
  - Flags then clear.
- Arithmetic limits: all 16-bit counters saturate at 0xFFFF; `rx_total_bytes` saturates at 0xFFFFFFFF.
- `rx_pass` = `rx_done_led` and `rx_err_pkt_cnt`==0.

## Timing
- All outputs are registered. Reset value of every output is 0, and the state is WAIT_ALIGN.
- Counters reflect a frame one cycle after its tlast beat.
- `rx_done_led` and `rx_pass` assert in the same cycle as the final counter update. They stay high until `restart` or reset.
- The monitor accepts a new frame on the beat immediately after a tlast beat; zero idle cycles between frames is legal.
- `rx_busy_led` follows the state with one cycle of register delay.
- `rx_aligned` falling takes effect on the next edge; a beat in that same cycle is discarded.
- An `aresetn` assertion mid-frame clears everything asynchronously.

## Test plan
- Good run, `PKT_NUM`=4, `PKT_SIZE`=522:
  - Stimulus: 4 frames of 9 beats each, back to back. Each frame has 8 full beats and a last beat with `tkeep`=0x3FF, carrying the correct pattern.
  - Required: `rx_pkt_cnt`=4, `rx_total_bytes`=2088, all error counters 0, `rx_done_led`=`rx_pass`=1 one cycle after the 4th tlast.
- Corrupted byte: offset 300 (beat 4, lane 44) set to 0x00 in frame 2.
  - Required: `rx_data_err_cnt`=1, `rx_err_pkt_cnt`=1, `rx_pass`=0 at done.
- Length faults:
  - A 521-byte frame (last `tkeep`=0x1FF) → `rx_len_err_cnt`=1.
  - A mid-frame beat with `tkeep`=0x0FFF…F → a further +1.
  - Both cases also add to `rx_err_pkt_cnt`.
- FCS plus data fault: `tuser`=1 on tlast in a frame that also carries a data error.
  - Required: `rx_fcs_err_cnt`=1, `rx_data_err_cnt`=1, `rx_err_pkt_cnt`=1 (counted once).
- Alignment loss: drop `rx_aligned` after beat 3 of frame 1, then re-align and send 4 good frames.
  - Required: the partial frame is not counted; `rx_pkt_cnt`=4; `rx_pass`=1.
- Restart and reset:
  - `restart` pulse in DONE → all counters 0 and state WAIT_ALIGN on the next cycle.
  - `aresetn` low mid-frame → all outputs 0 immediately.
  - A subsequent 4-frame run passes.

Source files
------------

// File: rtl/cmac_usplus_0_axis_pkt_mon.sv
// CMAC RX AXI4-Stream packet monitor: checks length, byte pattern and FCS of
// each received frame, counts good/bad frames and flags done/pass after PKT_NUM.
//
// state      | meaning
// WAIT_ALIGN | waiting for stat_rx_aligned, beats ignored
// ARMED      | between frames, next valid beat starts a frame
// RECV       | inside a multi-beat frame
// DONE       | PKT_NUM frames completed, beats ignored until restart
module cmac_usplus_0_axis_pkt_mon #(
  parameter int PKT_NUM  = 1000,
  parameter int PKT_SIZE = 522
) (
  input  logic         aclk,
  input  logic         aresetn,
  input  logic         rx_aligned,
  input  logic         restart,
  input  logic         rx_axis_tvalid,
  input  logic [511:0] rx_axis_tdata,
  input  logic [63:0]  rx_axis_tkeep,
  input  logic         rx_axis_tlast,
  input  logic         rx_axis_tuser,
  output logic [15:0]  rx_pkt_cnt,
  output logic [15:0]  rx_err_pkt_cnt,
  output logic [15:0]  rx_len_err_cnt,
  output logic [15:0]  rx_data_err_cnt,
  output logic [15:0]  rx_fcs_err_cnt,
  output logic [31:0]  rx_total_bytes,
  output logic         rx_busy_led,
  output logic         rx_done_led,
  output logic         rx_pass
);

  typedef enum logic [1:0] {
    S_WAIT_ALIGN = 2'd0,
    S_ARMED      = 2'd1,
    S_RECV       = 2'd2,
    S_DONE       = 2'd3
  } state_t;

  localparam logic [13:0] LEN_MAX = 14'h3FFF;

  state_t      state_q, state_d;
  logic [13:0] off_q, off_d;
  logic [13:0] len_q, len_d;
  logic        len_err_q, len_err_d;
  logic        data_err_q, data_err_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [15:0] len_cnt_q, len_cnt_d;
  logic [15:0] data_cnt_q, data_cnt_d;
  logic [15:0] fcs_cnt_q, fcs_cnt_d;
  logic [31:0] tot_q, tot_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        busy_q, busy_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
    return (en && (v != 16'hFFFF)) ? v + 16'd1 : v;
  endfunction

  // Per-beat analysis: lane popcount and pattern compare against byte offset.
  logic [6:0] keep_pop;
  logic       beat_data_err;
  always_comb begin
    keep_pop      = 7'd0;
    beat_data_err = 1'b0;
    for (int i = 0; i < 64; i++) begin
      keep_pop = keep_pop + 7'(rx_axis_tkeep[i]);
      if (rx_axis_tkeep[i] && (rx_axis_tdata[8*i +: 8] != (off_q[7:0] + 8'(i))))
        beat_data_err = 1'b1;
    end
  end

  logic        keep_full;
  logic        keep_contig;
  logic        beat_len_err;
  logic [14:0] len_sum;
  logic [13:0] len_next;
  logic [14:0] off_sum;
  logic [13:0] off_next;
  logic        frame_len_err;
  logic        frame_data_err;
  logic        frame_any_err;
  logic [32:0] tot_sum;
  logic [31:0] tot_next;

  // A legal last-beat keep is 2^m-1 with m >= 1: ones packed from lane 0.
  assign keep_full    = &rx_axis_tkeep;
  assign keep_contig  = (rx_axis_tkeep != 64'd0) &&
                        ((rx_axis_tkeep & (rx_axis_tkeep + 64'd1)) == 64'd0);
  assign beat_len_err = rx_axis_tlast ? !keep_contig : !keep_full;

  assign len_sum  = {1'b0, len_q} + {8'd0, keep_pop};
  assign len_next = len_sum[14] ? LEN_MAX : len_sum[13:0];
  assign off_sum  = {1'b0, off_q} + 15'd64;
  assign off_next = off_sum[14] ? LEN_MAX : off_sum[13:0];

  assign frame_len_err  = len_err_q | beat_len_err | (len_next == LEN_MAX) |
                          (len_next != 14'(PKT_SIZE));
  assign frame_data_err = data_err_q | beat_data_err;
  assign frame_any_err  = frame_len_err | frame_data_err | rx_axis_tuser;

  assign tot_sum  = {1'b0, tot_q} + {19'd0, len_next};
  assign tot_next = tot_sum[32] ? 32'hFFFF_FFFF : tot_sum[31:0];

  always_comb begin
    state_d    = state_q;
    off_d      = off_q;
    len_d      = len_q;
    len_err_d  = len_err_q;
    data_err_d = data_err_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_cnt_d  = err_cnt_q;
    len_cnt_d  = len_cnt_q;
    data_cnt_d = data_cnt_q;
    fcs_cnt_d  = fcs_cnt_q;
    tot_d      = tot_q;
    done_d     = done_q;

    if (restart) begin
      state_d    = S_WAIT_ALIGN;
      off_d      = 14'd0;
      len_d      = 14'd0;
      len_err_d  = 1'b0;
      data_err_d = 1'b0;
      pkt_cnt_d  = 16'd0;
      err_cnt_d  = 16'd0;
      len_cnt_d  = 16'd0;
      data_cnt_d = 16'd0;
      fcs_cnt_d  = 16'd0;
      tot_d      = 32'd0;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        S_WAIT_ALIGN: begin
          off_d      = 14'd0;
          len_d      = 14'd0;
          len_err_d  = 1'b0;
          data_err_d = 1'b0;
          if (rx_aligned) state_d = S_ARMED;
        end
        S_ARMED, S_RECV: begin
          if (!rx_aligned) begin
            // partial frame dropped, counters keep their values
            state_d    = S_WAIT_ALIGN;
            off_d      = 14'd0;
            len_d      = 14'd0;
            len_err_d  = 1'b0;
            data_err_d = 1'b0;
          end else if (rx_axis_tvalid) begin
            if (rx_axis_tlast) begin
              pkt_cnt_d  = sat_inc16(pkt_cnt_q, 1'b1);
              err_cnt_d  = sat_inc16(err_cnt_q, frame_any_err);
              len_cnt_d  = sat_inc16(len_cnt_q, frame_len_err);
              data_cnt_d = sat_inc16(data_cnt_q, frame_data_err);
              fcs_cnt_d  = sat_inc16(fcs_cnt_q, rx_axis_tuser);
              tot_d      = tot_next;
              off_d      = 14'd0;
              len_d      = 14'd0;
              len_err_d  = 1'b0;
              data_err_d = 1'b0;
              if (pkt_cnt_d >= 16'(PKT_NUM)) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = S_ARMED;
              end
            end else begin
              off_d      = off_next;
              len_d      = len_next;
              len_err_d  = len_err_q | beat_len_err | (len_next == LEN_MAX);
              data_err_d = frame_data_err;
              state_d    = S_RECV;
            end
          end
        end
        S_DONE: begin
        end
        default: state_d = S_WAIT_ALIGN;
      endcase
    end
  end

  assign pass_d = done_d && (err_cnt_d == 16'd0);
  assign busy_d = (state_q == S_ARMED) || (state_q == S_RECV);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_WAIT_ALIGN;
      off_q      <= 14'd0;
      len_q      <= 14'd0;
      len_err_q  <= 1'b0;
      data_err_q <= 1'b0;
      pkt_cnt_q  <= 16'd0;
      err_cnt_q  <= 16'd0;
      len_cnt_q  <= 16'd0;
      data_cnt_q <= 16'd0;
      fcs_cnt_q  <= 16'd0;
      tot_q      <= 32'd0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      off_q      <= off_d;
      len_q      <= len_d;
      len_err_q  <= len_err_d;
      data_err_q <= data_err_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_cnt_q  <= err_cnt_d;
      len_cnt_q  <= len_cnt_d;
      data_cnt_q <= data_cnt_d;
      fcs_cnt_q  <= fcs_cnt_d;
      tot_q      <= tot_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      busy_q     <= busy_d;
    end
  end

  assign rx_pkt_cnt      = pkt_cnt_q;
  assign rx_err_pkt_cnt  = err_cnt_q;
  assign rx_len_err_cnt  = len_cnt_q;
  assign rx_data_err_cnt = data_cnt_q;
  assign rx_fcs_err_cnt  = fcs_cnt_q;
  assign rx_total_bytes  = tot_q;
  assign rx_busy_led     = busy_q;
  assign rx_done_led     = done_q;
  assign rx_pass         = pass_q;

endmodule
